nettlp_tx_sched: RTL and testbench

Packet-atomic weighted round-robin scheduler that shares the single Ethernet TX encapsulation path between the three NetTLP transmit sources: the TLP stream, NetTLP command responses and PCIe config responses. It sits between the source FIFOs and the Eth/IP/UDP encapsulator. Each packet is granted whole: once a source wins, its beats pass until `tlast`. Arbitration runs on per-source weights set from adapter registers.

---
 rtl/nettlp_tx_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_nettlp_tx_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nettlp_tx_sched.sv
// nettlp_tx_sched
//
// Packet-atomic weighted round-robin scheduler. It shares the single Ethernet
// TX encapsulation path between three NetTLP transmit sources:
//   source 0 = TLP stream, source 1 = command responses, source 2 = PCIe
//   config responses.
// A source that wins arbitration keeps the path until its tlast handshake.
// Each source may send cfg_weightN packets per turn. A weight of 0 counts as 1.
//
// Parameters
//   CRED_W  width of the weight inputs and of the credit counter
//   STAT_W  width of the per-source packet counters
//
// Ports
//   eth_clk, eth_rst_n        clock; synchronous active-low reset
//   sN_tvalid/tdata/tkeep/tlast/tready   source streams (N = 0..2)
//   m_tvalid/tdata/tkeep/tlast, m_tready encapsulator-side stream
//   m_tsrc                    index of the granted source
//   cfg_weight0..2            packets per turn for each source
//   busy                      high while a packet is in flight
//   stat_pkt0..2              packets forwarded per source
//
// Build option
//   NETTLP_TX_SCHED_STATS_EN  builds the per-source packet counters.
//                             Without it, stat_pkt0..2 are tied to zero.

module nettlp_tx_sched #(
  parameter int unsigned CRED_W = 4,
  parameter int unsigned STAT_W = 32
) (
  input  logic              eth_clk,
  input  logic              eth_rst_n,

  input  logic              s0_tvalid,
  input  logic [63:0]       s0_tdata,
  input  logic [7:0]        s0_tkeep,
  input  logic              s0_tlast,
  output logic              s0_tready,

  input  logic              s1_tvalid,
  input  logic [63:0]       s1_tdata,
  input  logic [7:0]        s1_tkeep,
  input  logic              s1_tlast,
  output logic              s1_tready,

  input  logic              s2_tvalid,
  input  logic [63:0]       s2_tdata,
  input  logic [7:0]        s2_tkeep,
  input  logic              s2_tlast,
  output logic              s2_tready,

  output logic              m_tvalid,
  output logic [63:0]       m_tdata,
  output logic [7:0]        m_tkeep,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [1:0]        m_tsrc,

  input  logic [CRED_W-1:0] cfg_weight0,
  input  logic [CRED_W-1:0] cfg_weight1,
  input  logic [CRED_W-1:0] cfg_weight2,

  output logic              busy,

  output logic [STAT_W-1:0] stat_pkt0,
  output logic [STAT_W-1:0] stat_pkt1,
  output logic [STAT_W-1:0] stat_pkt2
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [CRED_W-1:0]   cred_q, cred_d;
  logic [1:0]          gnt_q, gnt_d;

  logic [2:0]          req;
  logic                keep_turn;
  logic [1:0]          nxt1, nxt2, pick;
  logic [CRED_W-1:0]   w_raw, w_eff;
  logic                xfer;
  logic                last_hs;

  // Mod-3 increment. ptr only ever holds 0..2.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign req = {s2_tvalid, s1_tvalid, s0_tvalid};

  // Rotation search: ptr+1, ptr+2, then ptr itself. After reset (ptr=0,
  // cred=0) this gives the fixed order 1, 2, 0.
  always_comb begin
    nxt1 = inc3(ptr_q);
    nxt2 = inc3(nxt1);
    if (req[nxt1])      pick = nxt1;
    else if (req[nxt2]) pick = nxt2;
    else                pick = ptr_q;
  end

  assign keep_turn = req[ptr_q] && (cred_q != '0);

  always_comb begin
    unique case (pick)
      2'd0:    w_raw = cfg_weight0;
      2'd1:    w_raw = cfg_weight1;
      default: w_raw = cfg_weight2;
    endcase
    w_eff = (w_raw == '0) ? CRED_W'(1) : w_raw;
  end

  // The outputs are also gated by the reset input. This makes the grant drop
  // in the same cycle reset is asserted, not only at the next clock edge.
  assign xfer = (state_q == XFER) && eth_rst_n;
  assign busy = xfer;
  assign m_tsrc = eth_rst_n ? gnt_q : 2'd0;

  always_comb begin
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    s2_tready = 1'b0;
    if (xfer) begin
      unique case (gnt_q)
        2'd0: begin
          m_tvalid  = s0_tvalid;
          m_tdata   = s0_tdata;
          m_tkeep   = s0_tkeep;
          m_tlast   = s0_tlast;
          s0_tready = m_tready;
        end
        2'd1: begin
          m_tvalid  = s1_tvalid;
          m_tdata   = s1_tdata;
          m_tkeep   = s1_tkeep;
          m_tlast   = s1_tlast;
          s1_tready = m_tready;
        end
        default: begin
          m_tvalid  = s2_tvalid;
          m_tdata   = s2_tdata;
          m_tkeep   = s2_tkeep;
          m_tlast   = s2_tlast;
          s2_tready = m_tready;
        end
      endcase
    end
  end

  assign last_hs = m_tvalid && m_tready && m_tlast;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cred_d  = cred_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          if (keep_turn) begin
            gnt_d  = ptr_q;
            cred_d = cred_q - CRED_W'(1);
          end else begin
            ptr_d  = pick;
            gnt_d  = pick;
            cred_d = w_eff - CRED_W'(1);
          end
          state_d = XFER;
        end
      end
      default: begin
        if (last_hs) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge eth_clk) begin
    if (!eth_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cred_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef NETTLP_TX_SCHED_STATS_EN
  logic [STAT_W-1:0] stat0_q, stat1_q, stat2_q;

  always_ff @(posedge eth_clk) begin
    if (!eth_rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
      stat2_q <= '0;
    end else if (last_hs) begin
      unique case (gnt_q)
        2'd0:    stat0_q <= stat0_q + STAT_W'(1);
        2'd1:    stat1_q <= stat1_q + STAT_W'(1);
        default: stat2_q <= stat2_q + STAT_W'(1);
      endcase
    end
  end

  assign stat_pkt0 = stat0_q;
  assign stat_pkt1 = stat1_q;
  assign stat_pkt2 = stat2_q;
`else
  assign stat_pkt0 = '0;
  assign stat_pkt1 = '0;
  assign stat_pkt2 = '0;
`endif

endmodule

// File: tb/tb_nettlp_tx_sched.sv
// tb_nettlp_tx_sched
//
// Randomized bench for nettlp_tx_sched. Source packets come from per-source
// counters of pending packets and beats. A packet-level scheduler model
// (turn owner plus packets left in the turn) predicts every output on every
// cycle. The bench also compares grant sequences against fixed expected lists.

module tb_nettlp_tx_sched;
  localparam int unsigned CRED_W = 4;
  localparam int unsigned STAT_W = 32;

  logic eth_clk = 1'b0;
  logic eth_rst_n;
  always #5 eth_clk = ~eth_clk;

  logic              sv[3];
  logic [63:0]       sd[3];
  logic [7:0]        sk[3];
  logic              sl[3];
  logic              s_rdy[3];
  logic              m_tvalid, m_tlast, m_tready, busy;
  logic [63:0]       m_tdata;
  logic [7:0]        m_tkeep;
  logic [1:0]        m_tsrc;
  logic [CRED_W-1:0] wt[3];
  logic [STAT_W-1:0] stat[3];

  nettlp_tx_sched #(.CRED_W(CRED_W), .STAT_W(STAT_W)) dut (
    .eth_clk(eth_clk), .eth_rst_n(eth_rst_n),
    .s0_tvalid(sv[0]), .s0_tdata(sd[0]), .s0_tkeep(sk[0]), .s0_tlast(sl[0]), .s0_tready(s_rdy[0]),
    .s1_tvalid(sv[1]), .s1_tdata(sd[1]), .s1_tkeep(sk[1]), .s1_tlast(sl[1]), .s1_tready(s_rdy[1]),
    .s2_tvalid(sv[2]), .s2_tdata(sd[2]), .s2_tkeep(sk[2]), .s2_tlast(sl[2]), .s2_tready(s_rdy[2]),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tready(m_tready), .m_tsrc(m_tsrc),
    .cfg_weight0(wt[0]), .cfg_weight1(wt[1]), .cfg_weight2(wt[2]),
    .busy(busy),
    .stat_pkt0(stat[0]), .stat_pkt1(stat[1]), .stat_pkt2(stat[2])
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Source generator state.
  int unsigned pk_left[3];
  int unsigned bt_left[3];
  int unsigned stall[3];
  int unsigned fixlen;
  int unsigned vprob;
  int unsigned rprob;

  // Scheduler model: a packet is in flight (mb) from source mg; source mturn
  // owns the turn and may still send mleft more packets in it.
  bit          mb;
  int unsigned mg, mturn, mleft;
  int unsigned mstat[3];
  int unsigned gq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_beat(input int unsigned s);
    sd[s] = {$urandom, $urandom};
    sk[s] = 8'($urandom);
    sl[s] = (bt_left[s] == 1);
  endtask

  task automatic load_pkt(input int unsigned s);
    bt_left[s] = (fixlen != 0) ? fixlen : $urandom_range(1, 4);
    new_beat(s);
  endtask

  task automatic give(input int unsigned s, input int unsigned n);
    if (pk_left[s] == 0 && n > 0) begin
      pk_left[s] = n;
      load_pkt(s);
    end else begin
      pk_left[s] += n;
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, let the
  // rising edge pass, then advance the model at the next falling edge.
  task automatic step();
    bit          act;
    bit          hs[3];
    int unsigned g;
    logic [2:0]  e_rdy;
    for (int s = 0; s < 3; s++) begin
      if (stall[s] > 0) begin
        sv[s] = 1'b0;
        stall[s]--;
      end else begin
        sv[s] = (pk_left[s] > 0) && ($urandom_range(0, 99) < vprob);
      end
    end
    m_tready = ($urandom_range(0, 99) < rprob);
    #1;
    act = eth_rst_n && mb;
    check("m_tvalid", 64'(m_tvalid), act ? 64'(sv[mg]) : 64'd0);
    check("m_tdata",  m_tdata,       act ? sd[mg] : 64'd0);
    check("m_tkeep",  64'(m_tkeep),  act ? 64'(sk[mg]) : 64'd0);
    check("m_tlast",  64'(m_tlast),  act ? 64'(sl[mg]) : 64'd0);
    check("m_tsrc",   64'(m_tsrc),   eth_rst_n ? 64'(mg) : 64'd0);
    check("busy",     64'(busy),     64'(act));
    e_rdy = '0;
    if (act) e_rdy[mg] = m_tready;
    check("tready", 64'({s_rdy[2], s_rdy[1], s_rdy[0]}), 64'(e_rdy));
    for (int s = 0; s < 3; s++) begin
`ifdef NETTLP_TX_SCHED_STATS_EN
      check("stat_pkt", 64'(stat[s]), 64'(STAT_W'(mstat[s])));
`else
      check("stat_pkt", 64'(stat[s]), 64'd0);
`endif
      hs[s] = act && (mg == s) && m_tready && sv[s];
    end
    @(posedge eth_clk);
    @(negedge eth_clk);
    if (!eth_rst_n) begin
      mb = 0; mg = 0; mturn = 0; mleft = 0;
      for (int s = 0; s < 3; s++) begin
        mstat[s] = 0; pk_left[s] = 0; stall[s] = 0;
      end
    end else if (mb) begin
      if (hs[mg] && sl[mg]) begin
        mb = 0;
        mstat[mg]++;
      end
    end else if (sv[0] || sv[1] || sv[2]) begin
      if (sv[mturn] && mleft > 0) begin
        g = mturn;
        mleft--;
      end else begin
        g = mturn;
        for (int k = 3; k >= 1; k--) begin
          if (sv[(mturn + k) % 3]) g = (mturn + k) % 3;
        end
        mturn = g;
        mleft = ((wt[g] == 0) ? 1 : int'(wt[g])) - 1;
      end
      mg = g;
      mb = 1;
      gq.push_back(g);
    end
    for (int s = 0; s < 3; s++) begin
      if (hs[s]) begin
        if (sl[s]) begin
          pk_left[s]--;
          if (pk_left[s] > 0) load_pkt(s);
        end else begin
          bt_left[s]--;
          new_beat(s);
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int unsigned max, output int unsigned n);
    n = 0;
    while ((pk_left[0] + pk_left[1] + pk_left[2] > 0 || mb) && n < max) begin
      step();
      n++;
    end
    check(tag, 64'(n < max), 64'd1);
  endtask

  task automatic do_reset();
    eth_rst_n = 1'b0;
    step();
    step();
    eth_rst_n = 1'b1;
    gq.delete();
  endtask

  task automatic check_gq(input string tag, input int unsigned exp[], input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) begin
      if (i < gq.size()) check(tag, 64'(gq[i]), 64'(exp[i]));
      else               check(tag, 64'hff, 64'(exp[i]));
    end
  endtask

  int unsigned n;
  int unsigned seq_a[] = '{1, 2, 0, 0, 1, 2, 0, 0};
  int unsigned seq_b[] = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
  int unsigned seq_c[] = '{0, 1, 2};

  initial begin
    for (int s = 0; s < 3; s++) begin
      sv[s] = 0; sd[s] = '0; sk[s] = '0; sl[s] = 0;
      pk_left[s] = 0; bt_left[s] = 0; stall[s] = 0; mstat[s] = 0;
      wt[s] = CRED_W'(1);
    end
    mb = 0; mg = 0; mturn = 0; mleft = 0;
    m_tready = 1'b0;
    fixlen = 0; vprob = 100; rprob = 100;
    eth_rst_n = 1'b0;
    repeat (2) @(posedge eth_clk);
    @(negedge eth_clk);
    eth_rst_n = 1'b1;

    // Reset state: quiet for 10 cycles.
    for (int i = 0; i < 10; i++) step();

    // Single 3-beat packet from s1: grant cycle + 3 beats.
    gq.delete();
    fixlen = 3;
    give(1, 1);
    drain("p1_drain", 50, n);
    check("p1_cycles", 64'(n), 64'd4);
    check("p1_gnt", 64'(gq.size() == 1 ? gq[0] : 99), 64'd1);

    // Weights 2/1/1, backlog of 1-beat packets.
    do_reset();
    wt[0] = 2; wt[1] = 1; wt[2] = 1;
    fixlen = 1;
    for (int s = 0; s < 3; s++) give(s, 8);
    drain("p2_drain", 200, n);
    check_gq("p2_seq", seq_a, 8);

    // Weight 0 on s2 counts as 1.
    do_reset();
    wt[0] = 1; wt[1] = 1; wt[2] = 0;
    for (int s = 0; s < 3; s++) give(s, 6);
    drain("p3_drain", 200, n);
    check_gq("p3_seq", seq_b, 9);

    // s0 stalls mid-packet while s1 and s2 wait.
    do_reset();
    wt[2] = 1;
    fixlen = 4;
    give(0, 1);
    step();
    give(1, 1);
    give(2, 1);
    step();
    stall[0] = 5;
    drain("p4_drain", 100, n);
    check_gq("p4_seq", seq_c, 3);

    // Reset while the second beat of a 4-beat packet is presented.
    do_reset();
    give(0, 1);
    step();
    step();
    eth_rst_n = 1'b0;
    step();
    eth_rst_n = 1'b1;
    step();
    check("p5_busy", 64'(busy), 64'd0);
    check("p5_rdy0", 64'(s_rdy[0]), 64'd0);

    // 5/3/2 packets with random valid and ready gaps.
    do_reset();
    fixlen = 0; vprob = 70; rprob = 70;
    give(0, 5); give(1, 3); give(2, 2);
    drain("p6_drain", 2000, n);
`ifdef NETTLP_TX_SCHED_STATS_EN
    check("p6_stat0", 64'(stat[0]), 64'd5);
    check("p6_stat1", 64'(stat[1]), 64'd3);
    check("p6_stat2", 64'(stat[2]), 64'd2);
`else
    check("p6_stat0", 64'(stat[0]), 64'd0);
`endif

    // Random traffic, random weights (also changed mid-run).
    do_reset();
    for (int r = 0; r < 3; r++) begin
      vprob = $urandom_range(40, 100);
      rprob = $urandom_range(40, 100);
      for (int i = 0; i < 1200; i++) begin
        if ($urandom_range(0, 40) == 0)
          for (int s = 0; s < 3; s++) wt[s] = CRED_W'($urandom);
        for (int s = 0; s < 3; s++)
          if (pk_left[s] < 2 && $urandom_range(0, 9) == 0) give(s, $urandom_range(1, 4));
        step();
      end
      drain("p7_drain", 3000, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
